// File: rtl/ans_freq_model_pkg.sv
// Shared widths and FSM encodings for the ANS symbol-frequency model.
package ans_freq_model_pkg;

  localparam int SYM_WIDTH   = 2;
  localparam int CNT_WIDTH   = 8;
  localparam int STATE_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUILD = 2'd1,
    ST_RUN   = 2'd2
  } fm_state_t;

endpackage

// File: rtl/ans_freq_model_if.sv
// Symbol-in / {count, cumulative}-out handshake bundle between the model and the encoder.
interface ans_freq_model_if
  import ans_freq_model_pkg::*;
#(
  parameter int ALPHA_BITS = SYM_WIDTH,
  parameter int CNT_W      = CNT_WIDTH,
  parameter int ST_W       = STATE_WIDTH
);
  logic [ALPHA_BITS-1:0] sym_in;
  logic                  sym_vld;
  logic                  sym_rdy;
  logic [CNT_W-1:0]      s_count;
  logic [ST_W-1:0]       s_cumulative;
  logic [ST_W-1:0]       total_count;
  logic                  out_vld;
  logic                  out_rdy;

  modport master (
    output sym_in, sym_vld, out_rdy,
    input  sym_rdy, s_count, s_cumulative, total_count, out_vld
  );

  modport slave (
    input  sym_in, sym_vld, out_rdy,
    output sym_rdy, s_count, s_cumulative, total_count, out_vld
  );
endinterface

// File: rtl/ans_freq_table.sv
// Per-symbol count and cumulative register file: one write port each,
// a build-index read port and a lookup read port.
module ans_freq_table #(
  parameter int ALPHA_BITS = 2,
  parameter int CNT_W      = 8,
  parameter int ST_W       = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cnt_we,
  input  logic [ALPHA_BITS-1:0] i_cnt_addr,
  input  logic [CNT_W-1:0]      i_cnt_data,
  input  logic                  i_cum_we,
  input  logic [ALPHA_BITS-1:0] i_cum_addr,
  input  logic [ST_W-1:0]       i_cum_data,
  input  logic [ALPHA_BITS-1:0] i_bld_idx,
  output logic [CNT_W-1:0]      o_bld_count,
  input  logic [ALPHA_BITS-1:0] i_lk_idx,
  output logic [CNT_W-1:0]      o_lk_count,
  output logic [ST_W-1:0]       o_lk_cum
);
  localparam int N = 2 ** ALPHA_BITS;

  logic [CNT_W-1:0] r_cnt [N];
  logic [ST_W-1:0]  r_cum [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        r_cnt[k] <= '0;
        r_cum[k] <= '0;
      end
    end else begin
      if (i_cnt_we) r_cnt[i_cnt_addr] <= i_cnt_data;
      if (i_cum_we) r_cum[i_cum_addr] <= i_cum_data;
    end
  end

  assign o_bld_count = r_cnt[i_bld_idx];
  assign o_lk_count  = r_cnt[i_lk_idx];
  assign o_lk_cum    = r_cum[i_lk_idx];
endmodule

// File: rtl/ans_freq_model.sv
// Frequency model ahead of the ANS encoder: programmable counts, cumulative
// build FSM, and a one-deep registered symbol-to-{count, cum} lookup stage.
module ans_freq_model
  import ans_freq_model_pkg::*;
#(
  parameter int ALPHA_BITS = SYM_WIDTH,
  parameter int CNT_W      = CNT_WIDTH,
  parameter int ST_W       = STATE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  cfg_we,
  input  logic [ALPHA_BITS-1:0] cfg_addr,
  input  logic [CNT_W-1:0]      cfg_count,
  input  logic                  cfg_start,
  output logic                  busy,
  output logic                  err_zero,
  output logic                  err_ovf,
  ans_freq_model_if.slave       bus
);
  fm_state_t             r_state;
  logic [ALPHA_BITS-1:0] r_idx;
  logic [ST_W-1:0]       r_acc;
  logic [ST_W-1:0]       r_total;
  logic                  r_err_zero;
  logic                  r_err_ovf;
  logic [CNT_W-1:0]      r_s_count_p1;
  logic [ST_W-1:0]       r_s_cum_p1;
  logic                  r_out_vld_p1;

  logic [CNT_W-1:0] w_bld_count;
  logic [CNT_W-1:0] w_lk_count;
  logic [ST_W-1:0]  w_lk_cum;
  logic [ST_W:0]    w_sum;
  logic             w_sym_rdy;
  logic             w_accept;

  // Extra top bit of the sum is the overflow carry.
  function automatic logic [ST_W:0] acc_add(input logic [ST_W-1:0] a, input logic [CNT_W-1:0] c);
    return {1'b0, a} + (ST_W+1)'(c);
  endfunction

  ans_freq_table #(.ALPHA_BITS(ALPHA_BITS), .CNT_W(CNT_W), .ST_W(ST_W)) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cnt_we   (ena & cfg_we & (r_state != ST_BUILD)),
    .i_cnt_addr (cfg_addr),
    .i_cnt_data (cfg_count),
    .i_cum_we   (ena & (r_state == ST_BUILD)),
    .i_cum_addr (r_idx),
    .i_cum_data (r_acc),
    .i_bld_idx  (r_idx),
    .o_bld_count(w_bld_count),
    .i_lk_idx   (bus.sym_in),
    .o_lk_count (w_lk_count),
    .o_lk_cum   (w_lk_cum)
  );

  assign w_sum     = acc_add(r_acc, w_bld_count);
  assign w_sym_rdy = ena & (r_state == ST_RUN) & (!r_out_vld_p1 | bus.out_rdy);
  assign w_accept  = w_sym_rdy & bus.sym_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_acc        <= '0;
      r_total      <= '0;
      r_err_zero   <= 1'b0;
      r_err_ovf    <= 1'b0;
      r_s_count_p1 <= '0;
      r_s_cum_p1   <= '0;
      r_out_vld_p1 <= 1'b0;
    end else if (ena) begin
      // Output stage p1: zero-count symbols are consumed without producing an output.
      if (w_accept) begin
        if (w_lk_count != '0) begin
          r_s_count_p1 <= w_lk_count;
          r_s_cum_p1   <= w_lk_cum;
          r_out_vld_p1 <= 1'b1;
        end else begin
          r_out_vld_p1 <= 1'b0;
          r_err_zero   <= 1'b1;
        end
      end else if (bus.out_rdy) begin
        r_out_vld_p1 <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (cfg_start) begin
            r_state    <= ST_BUILD;
            r_err_zero <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_acc      <= '0;
            r_idx      <= '0;
          end
        end
        ST_BUILD: begin
          if (w_sum[ST_W]) begin
            r_err_ovf <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_acc <= w_sum[ST_W-1:0];
            r_idx <= r_idx + 1'b1;
            if (&r_idx) begin
              r_total <= w_sum[ST_W-1:0];
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (cfg_we) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy             = (r_state == ST_BUILD);
  assign err_zero         = r_err_zero;
  assign err_ovf          = r_err_ovf;
  assign bus.sym_rdy      = w_sym_rdy;
  assign bus.s_count      = r_s_count_p1;
  assign bus.s_cumulative = r_s_cum_p1;
  assign bus.total_count  = r_total;
  assign bus.out_vld      = r_out_vld_p1;
endmodule

// File: tb/tb_ans_freq_model.sv
// Directed bench for ans_freq_model: lookup vector table plus hand sequences
// for backpressure, enable freeze, zero counts, overflow and mid-build reset.
module tb_ans_freq_model;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cfg_we, cfg_start;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_count;
  logic       busy, err_zero, err_ovf;

  logic       cfg_we2, cfg_start2;
  logic [1:0] cfg_addr2;
  logic [3:0] cfg_count2;
  logic       busy2, err_zero2, err_ovf2;

  int n_vec = 0;
  int n_bad = 0;

  ans_freq_model_if #(.ALPHA_BITS(2), .CNT_W(8), .ST_W(12)) bus1 ();
  ans_freq_model_if #(.ALPHA_BITS(2), .CNT_W(4), .ST_W(4))  bus2 ();

  ans_freq_model #(.ALPHA_BITS(2), .CNT_W(8), .ST_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_count(cfg_count), .cfg_start(cfg_start),
    .busy(busy), .err_zero(err_zero), .err_ovf(err_ovf), .bus(bus1)
  );

  ans_freq_model #(.ALPHA_BITS(2), .CNT_W(4), .ST_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cfg_we(cfg_we2), .cfg_addr(cfg_addr2), .cfg_count(cfg_count2), .cfg_start(cfg_start2),
    .busy(busy2), .err_zero(err_zero2), .err_ovf(err_ovf2), .bus(bus2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sym;
    int unsigned exp_cnt;
    int unsigned exp_cum;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic build1();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    vecs[0] = '{2'd0, 3, 0};
    vecs[1] = '{2'd1, 1, 3};
    vecs[2] = '{2'd2, 2, 4};
    vecs[3] = '{2'd3, 2, 6};
    vecs[4] = '{2'd3, 2, 6};
    vecs[5] = '{2'd0, 3, 0};
    vecs[6] = '{2'd2, 2, 4};

    rst_n = 1'b0; ena = 1'b1;
    cfg_we = 0; cfg_start = 0; cfg_addr = 0; cfg_count = 0;
    cfg_we2 = 0; cfg_start2 = 0; cfg_addr2 = 0; cfg_count2 = 0;
    bus1.sym_in = 0; bus1.sym_vld = 0; bus1.out_rdy = 0;
    bus2.sym_in = 0; bus2.sym_vld = 0; bus2.out_rdy = 0;
    #12;
    chk("rst_out_vld", bus1.out_vld, 0);
    chk("rst_sym_rdy", bus1.sym_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_total", bus1.total_count, 0);
    chk("rst_errs", {err_zero, err_ovf}, 0);
    rst_n = 1'b1;

    // Program {3,1,2,2} and build
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1; cfg_addr = 2'(i);
      cfg_count = (i == 0) ? 8'd3 : (i == 1) ? 8'd1 : 8'd2;
      tick();
    end
    cfg_we = 1'b0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("build_busy", busy, 1);
      tick();
    end
    chk("run_busy", busy, 0);
    chk("total_8", bus1.total_count, 8);

    // Back-to-back lookups, out_rdy high
    bus1.out_rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus1.sym_in = vecs[i].sym; bus1.sym_vld = 1'b1;
      #1;
      chk("vec_sym_rdy", bus1.sym_rdy, 1);
      tick();
      chk("vec_out_vld", bus1.out_vld, 1);
      chk("vec_count", bus1.s_count, vecs[i].exp_cnt);
      chk("vec_cum", bus1.s_cumulative, vecs[i].exp_cum);
    end
    bus1.sym_vld = 1'b0;
    tick();
    chk("drain_out_vld", bus1.out_vld, 0);

    // Backpressure: output held, sym_rdy low, resumes same cycle as out_rdy
    bus1.out_rdy = 1'b0; bus1.sym_in = 2'd1; bus1.sym_vld = 1'b1;
    tick();
    bus1.sym_in = 2'd2;
    for (int k = 0; k < 2; k++) begin
      chk("bp_sym_rdy", bus1.sym_rdy, 0);
      chk("bp_out_vld", bus1.out_vld, 1);
      chk("bp_hold_count", bus1.s_count, 1);
      chk("bp_hold_cum", bus1.s_cumulative, 3);
      tick();
    end
    bus1.out_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", bus1.sym_rdy, 1);
    tick();
    chk("bp_next_count", bus1.s_count, 2);
    chk("bp_next_cum", bus1.s_cumulative, 4);
    bus1.sym_vld = 1'b0;
    tick();
    chk("bp_drain", bus1.out_vld, 0);

    // ena low freezes everything
    bus1.out_rdy = 1'b0; bus1.sym_in = 2'd3; bus1.sym_vld = 1'b1;
    tick();
    bus1.sym_vld = 1'b0;
    ena = 1'b0; bus1.out_rdy = 1'b1;
    #1;
    chk("ena0_sym_rdy", bus1.sym_rdy, 0);
    tick(); tick();
    chk("ena0_out_vld", bus1.out_vld, 1);
    chk("ena0_count", bus1.s_count, 2);
    chk("ena0_cum", bus1.s_cumulative, 6);
    ena = 1'b1;
    tick();
    chk("ena1_drain", bus1.out_vld, 0);

    // Zero-count symbol: consumed silently, err_zero set
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_count = 8'd0;
    tick();
    cfg_we = 1'b0;
    chk("cfgwe_idle_rdy", bus1.sym_rdy, 0);
    build1();
    chk("total_7", bus1.total_count, 7);
    chk("err_zero_clear", err_zero, 0);
    bus1.sym_in = 2'd1; bus1.sym_vld = 1'b1;
    tick();
    chk("zero_out_vld", bus1.out_vld, 0);
    chk("zero_err", err_zero, 1);
    bus1.sym_in = 2'd2;
    tick();
    chk("after_zero_vld", bus1.out_vld, 1);
    chk("after_zero_count", bus1.s_count, 2);
    chk("after_zero_cum", bus1.s_cumulative, 3);
    bus1.sym_vld = 1'b0;
    tick();

    // Overflow on the 4-bit instance: {15,15,1,1}
    for (int i = 0; i < 4; i++) begin
      cfg_we2 = 1'b1; cfg_addr2 = 2'(i);
      cfg_count2 = (i < 2) ? 4'd15 : 4'd1;
      tick();
    end
    cfg_we2 = 1'b0;
    cfg_start2 = 1'b1;
    tick();
    cfg_start2 = 1'b0;
    chk("ovf_busy0", busy2, 1);
    tick();
    chk("ovf_busy1", busy2, 1);
    chk("ovf_not_yet", err_ovf2, 0);
    tick();
    chk("ovf_err", err_ovf2, 1);
    chk("ovf_idle", busy2, 0);
    bus2.sym_vld = 1'b1; bus2.out_rdy = 1'b1;
    #1;
    chk("ovf_sym_rdy", bus2.sym_rdy, 0);
    tick();
    chk("ovf_sym_rdy2", bus2.sym_rdy, 0);
    chk("ovf_out_vld", bus2.out_vld, 0);
    chk("ovf_total", bus2.total_count, 0);
    chk("ovf_err_zero", err_zero2, 0);

    // Reset in the middle of BUILD
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_count = 8'd1;
    tick();
    cfg_we = 1'b0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_total", bus1.total_count, 0);
    chk("mr_err_zero", err_zero, 0);
    chk("mr_out_vld", bus1.out_vld, 0);
    chk("mr_count", bus1.s_count, 0);
    chk("mr_cum", bus1.s_cumulative, 0);
    chk("mr_sym_rdy", bus1.sym_rdy, 0);
    chk("mr_err_ovf2", err_ovf2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
